// File: rtl/pc_fetch_unit_if.sv
// rtl/pc_fetch_unit_if.sv - decoder redirect, instruction-memory and IF/ID bundle for the fetch stage
interface pc_fetch_unit_if #(
  parameter int ADDR_W = 32
);
  logic              stall;
  logic              redirect_valid;
  logic [1:0]        next_instr_sel;
  logic [1:0]        jmp_sel;
  logic [ADDR_W-1:0] addr_i;
  logic [ADDR_W-1:0] addr_r;
  logic [ADDR_W-1:0] addr_b;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ready;
  logic [31:0]       imem_rdata;
  logic              fetch_valid;
  logic [31:0]       instr;
  logic [ADDR_W-1:0] instr_pc;
  logic [ADDR_W-1:0] instr_pc4;
  logic              flush;

  modport master (
    input  stall, redirect_valid, next_instr_sel, jmp_sel, addr_i, addr_r, addr_b,
    input  imem_ready, imem_rdata,
    output imem_req, imem_addr, fetch_valid, instr, instr_pc, instr_pc4, flush
  );

  modport slave (
    output stall, redirect_valid, next_instr_sel, jmp_sel, addr_i, addr_r, addr_b,
    output imem_ready, imem_rdata,
    input  imem_req, imem_addr, fetch_valid, instr, instr_pc, instr_pc4, flush
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - program counter and instruction fetch with redirect, drain and one-entry hold buffer
module pc_fetch_unit #(
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter int                INSTR_BYTES = 4
) (
  input  logic              clk,
  input  logic              rst,
  pc_fetch_unit_if.master   bus
);
  localparam logic [1:0] S_BOOT  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  localparam logic [ADDR_W-1:0] PC_INC = ADDR_W'(INSTR_BYTES);

  logic [1:0]        state, state_nx;
  logic [ADDR_W-1:0] pc, pc_nx;
  logic [ADDR_W-1:0] pend_pc, pend_pc_nx;
  logic [ADDR_W-1:0] pc_q, pc_q_nx;
  logic [31:0]       instr_q, instr_q_nx;

  logic              redirect_taken;
  logic [ADDR_W-1:0] target;
  logic              handshake;
  logic              deliver_mem;
  logic              deliver_buf;

  // Selects 01 and 11 both have bit 0 set; 00 and 10 are sequential.
  always_comb begin
    redirect_taken = bus.redirect_valid && bus.next_instr_sel[0];
    if (bus.next_instr_sel[1]) begin
      target = bus.addr_b;
    end else if (bus.jmp_sel == 2'b10) begin
      target = bus.addr_r;
    end else begin
      target = bus.addr_i;
    end
  end

  assign handshake   = ((state == S_FETCH) || (state == S_DRAIN)) && bus.imem_ready;
  assign deliver_mem = (state == S_FETCH) && bus.imem_ready && !bus.stall && !redirect_taken;
  assign deliver_buf = (state == S_HOLD) && !bus.stall && !redirect_taken;

  always_comb begin
    state_nx   = state;
    pc_nx      = pc;
    pend_pc_nx = pend_pc;
    pc_q_nx    = pc_q;
    instr_q_nx = instr_q;
    case (state)
      S_BOOT: begin
        state_nx = S_FETCH;
        if (redirect_taken) begin
          pc_nx = target;
        end
      end
      S_FETCH: begin
        if (redirect_taken) begin
          if (bus.imem_ready) begin
            pc_nx = target;
          end else begin
            pend_pc_nx = target;
            state_nx   = S_DRAIN;
          end
        end else if (bus.imem_ready) begin
          pc_nx = pc + PC_INC;
          if (bus.stall) begin
            instr_q_nx = bus.imem_rdata;
            pc_q_nx    = pc;
            state_nx   = S_HOLD;
          end
        end
      end
      S_DRAIN: begin
        // The outstanding request must complete; only its destination changes.
        if (redirect_taken) begin
          pend_pc_nx = target;
        end
        if (handshake) begin
          pc_nx    = redirect_taken ? target : pend_pc;
          state_nx = S_FETCH;
        end
      end
      default: begin
        if (redirect_taken) begin
          pc_nx    = target;
          state_nx = S_FETCH;
        end else if (!bus.stall) begin
          state_nx = S_FETCH;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_BOOT;
      pc      <= RESET_PC;
      pend_pc <= '0;
      pc_q    <= '0;
      instr_q <= '0;
    end else begin
      state   <= state_nx;
      pc      <= pc_nx;
      pend_pc <= pend_pc_nx;
      pc_q    <= pc_q_nx;
      instr_q <= instr_q_nx;
    end
  end

  // Delivery outputs are zeroed when idle so reset values hold without extra registers.
  always_comb begin
    bus.imem_req    = (state == S_FETCH) || (state == S_DRAIN);
    bus.imem_addr   = pc;
    bus.flush       = redirect_taken && !rst;
    bus.fetch_valid = deliver_mem || deliver_buf;
    if (deliver_mem) begin
      bus.instr    = bus.imem_rdata;
      bus.instr_pc = pc;
    end else if (deliver_buf) begin
      bus.instr    = instr_q;
      bus.instr_pc = pc_q;
    end else begin
      bus.instr    = '0;
      bus.instr_pc = '0;
    end
    bus.instr_pc4 = bus.instr_pc + PC_INC;
  end
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - randomized and directed check of pc_fetch_unit against a transaction-level model
module tb_pc_fetch_unit;
  localparam logic [31:0] RST_PC = 32'h100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pc_fetch_unit_if #(.ADDR_W(32)) bus ();

  pc_fetch_unit #(.ADDR_W(32), .RESET_PC(RST_PC), .INSTR_BYTES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [31:0] ins;
    logic [31:0] pc;
  } ent_t;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: pc register, boot flag, pending drain target, and a queue for the held instruction.
  bit          m_boot;
  bit          m_drain;
  logic [31:0] m_pc;
  logic [31:0] m_pend;
  ent_t        m_buf[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_boot  = 1;
    m_drain = 0;
    m_pc    = RST_PC;
    m_pend  = 0;
    m_buf.delete();
  endtask

  task automatic cycle(input logic r, input logic st, input logic rv, input logic [1:0] sel,
                       input logic [1:0] js, input logic [31:0] ai, input logic [31:0] ar,
                       input logic [31:0] ab, input logic rdy);
    logic        taken;
    logic [31:0] tgt;
    logic        e_req, e_valid;
    logic [31:0] e_instr, e_pc;
    @(negedge clk);
    rst                = r;
    bus.stall          = st;
    bus.redirect_valid = rv;
    bus.next_instr_sel = sel;
    bus.jmp_sel        = js;
    bus.addr_i         = ai;
    bus.addr_r         = ar;
    bus.addr_b         = ab;
    bus.imem_ready     = rdy;
    bus.imem_rdata     = mem_word(m_pc);
    #1;
    taken = rv && (sel == 2'b01 || sel == 2'b11);
    tgt   = (sel == 2'b11) ? ab : ((js == 2'b10) ? ar : ai);
    if (r) begin
      model_reset();
      check_eq("rst_req",   {63'd0, bus.imem_req},    64'd0);
      check_eq("rst_addr",  {32'd0, bus.imem_addr},   {32'd0, RST_PC});
      check_eq("rst_valid", {63'd0, bus.fetch_valid}, 64'd0);
      check_eq("rst_flush", {63'd0, bus.flush},       64'd0);
      check_eq("rst_instr", {32'd0, bus.instr},       64'd0);
      check_eq("rst_ipc",   {32'd0, bus.instr_pc},    64'd0);
      check_eq("rst_ipc4",  {32'd0, bus.instr_pc4},   64'd4);
      return;
    end
    e_req = !m_boot && (m_buf.size() == 0);
    if (m_boot || taken || st)            e_valid = 0;
    else if (m_buf.size() != 0)           e_valid = 1;
    else if (m_drain)                     e_valid = 0;
    else                                  e_valid = rdy;
    e_instr = 0;
    e_pc    = 0;
    if (e_valid) begin
      if (m_buf.size() != 0) begin
        e_instr = m_buf[0].ins;
        e_pc    = m_buf[0].pc;
      end else begin
        e_instr = mem_word(m_pc);
        e_pc    = m_pc;
      end
    end
    check_eq("flush", {63'd0, bus.flush},       {63'd0, taken});
    check_eq("req",   {63'd0, bus.imem_req},    {63'd0, e_req});
    if (e_req) check_eq("addr", {32'd0, bus.imem_addr}, {32'd0, m_pc});
    check_eq("valid", {63'd0, bus.fetch_valid}, {63'd0, e_valid});
    check_eq("instr", {32'd0, bus.instr},       {32'd0, e_instr});
    check_eq("ipc",   {32'd0, bus.instr_pc},    {32'd0, e_pc});
    check_eq("ipc4",  {32'd0, bus.instr_pc4},   {32'd0, e_pc + 32'd4});
    // Advance the model to the state after the coming rising edge.
    if (m_boot) begin
      m_boot = 0;
      if (taken) m_pc = tgt;
    end else if (m_buf.size() != 0) begin
      if (taken) begin
        m_buf.delete();
        m_pc = tgt;
      end else if (!st) begin
        m_buf.delete();
      end
    end else if (m_drain) begin
      if (taken) m_pend = tgt;
      if (rdy) begin
        m_pc    = m_pend;
        m_drain = 0;
      end
    end else if (taken) begin
      if (rdy) m_pc = tgt;
      else begin
        m_drain = 1;
        m_pend  = tgt;
      end
    end else if (rdy) begin
      if (st) m_buf.push_back('{ins: mem_word(m_pc), pc: m_pc});
      m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic idle(input logic rdy);
    cycle(0, 0, 0, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, rdy);
  endtask

  task automatic redir(input logic [1:0] sel, input logic [1:0] js, input logic [31:0] ai,
                       input logic [31:0] ar, input logic [31:0] ab, input logic rdy);
    cycle(0, 0, 1, sel, js, ai, ar, ab, rdy);
  endtask

  initial begin
    logic [31:0] hold_pc;
    model_reset();
    cycle(1, 0, 0, 2'b00, 2'b00, 0, 0, 0, 1);
    cycle(1, 0, 0, 2'b00, 2'b00, 0, 0, 0, 1);

    idle(1);
    check_eq("boot_req", {63'd0, bus.imem_req}, 64'd0);
    idle(1);
    check_eq("seq0", {32'd0, bus.imem_addr}, 64'h100);
    check_eq("seq0_pc4", {32'd0, bus.instr_pc4}, 64'h104);
    idle(1);
    check_eq("seq1", {32'd0, bus.imem_addr}, 64'h104);
    idle(1);
    check_eq("seq2", {32'd0, bus.imem_addr}, 64'h108);

    redir(2'b11, 2'b00, 0, 0, 32'h200, 1);
    check_eq("br_flush", {63'd0, bus.flush}, 64'd1);
    check_eq("br_valid", {63'd0, bus.fetch_valid}, 64'd0);
    redir(2'b01, 2'b10, 32'h400, 32'h300, 0, 1);
    check_eq("br_tgt", {32'd0, bus.imem_addr}, 64'h200);
    redir(2'b01, 2'b01, 32'h400, 32'h300, 0, 1);
    check_eq("jr_tgt", {32'd0, bus.imem_addr}, 64'h300);
    redir(2'b10, 2'b10, 32'h700, 32'h700, 32'h700, 1);
    check_eq("ji_tgt", {32'd0, bus.imem_addr}, 64'h400);
    check_eq("sel10_flush", {63'd0, bus.flush}, 64'd0);
    idle(1);
    check_eq("sel10_seq", {32'd0, bus.imem_addr}, 64'h404);

    redir(2'b11, 2'b00, 0, 0, 32'h500, 0);
    idle(0);
    check_eq("drain_hold", {32'd0, bus.imem_addr}, 64'h408);
    idle(1);
    check_eq("drain_discard", {63'd0, bus.fetch_valid}, 64'd0);
    idle(0);
    check_eq("drain_tgt", {32'd0, bus.imem_addr}, 64'h500);
    redir(2'b11, 2'b00, 0, 0, 32'h580, 0);
    redir(2'b01, 2'b00, 32'h600, 0, 0, 0);
    idle(1);
    idle(1);
    check_eq("drain_last", {32'd0, bus.imem_addr}, 64'h600);

    hold_pc = 32'h604;
    cycle(0, 1, 0, 2'b00, 2'b00, 0, 0, 0, 1);
    cycle(0, 1, 0, 2'b00, 2'b00, 0, 0, 0, 1);
    check_eq("hold_req", {63'd0, bus.imem_req}, 64'd0);
    idle(1);
    check_eq("hold_pc", {32'd0, bus.instr_pc}, {32'd0, hold_pc});
    check_eq("hold_instr", {32'd0, bus.instr}, {32'd0, mem_word(hold_pc)});
    idle(1);
    check_eq("hold_next", {32'd0, bus.imem_addr}, 64'h608);

    redir(2'b11, 2'b00, 0, 0, 32'hFFFF_FFFC, 1);
    idle(1);
    idle(1);
    check_eq("wrap", {32'd0, bus.imem_addr}, 64'h0);

    idle(0);
    cycle(1, 0, 0, 2'b00, 2'b00, 0, 0, 0, 1);
    check_eq("mid_rst_req", {63'd0, bus.imem_req}, 64'd0);

    for (int i = 0; i < 4000; i++) begin
      logic r;
      r = ($urandom_range(0, 199) == 0);
      cycle(r, ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
            2'($urandom), 2'($urandom), $urandom, $urandom, $urandom,
            ($urandom_range(0, 2) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Program-counter and instruction-fetch stage that consumes the 2-bit next-instruction select produced by the PC decoder. It holds the PC and drives the instruction-memory request/ready handshake. It applies branch/jump redirects (including redirects that arrive while a memory transaction is outstanding) and buffers one fetched instruction under back-pressure. It sits between the PC decoder and the IF/ID pipeline register.

## Interface
Parameters:
- ADDR_W, 32, width of PC and all addresses
- RESET_PC, 0, PC loaded on reset
- INSTR_BYTES, 4, sequential PC increment

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, asynchronous and active-high
- stall  in  1  IF/ID cannot accept an instruction this cycle
- redirect_valid  in  1  qualifies next_instr_sel and jmp_sel this cycle
- next_instr_sel  in  2  00 sequential, 01 jump, 11 branch, 10 treated as sequential
- jmp_sel  in  2  for jumps: 10 selects addr_r, any other value selects addr_i
- addr_i  in  ADDR_W  immediate jump target
- addr_r  in  ADDR_W  register jump target
- addr_b  in  ADDR_W  branch target
- imem_req  out  1  fetch request
- imem_addr  out  ADDR_W  fetch address
- imem_ready  in  1  memory returns imem_rdata this cycle; a transaction completes when imem_req && imem_ready
- imem_rdata  in  32  fetched instruction
- fetch_valid  out  1  instr/instr_pc valid for IF/ID this cycle
- instr  out  32  instruction to IF/ID
- instr_pc  out  ADDR_W  address of instr
- instr_pc4  out  ADDR_W  instr_pc + INSTR_BYTES (link value)
- flush  out  1  kill younger instructions in IF/ID and ID/EX

## Operation
- redirect_taken = redirect_valid && next_instr_sel in {01, 11}.
- Redirect target: sel 11 → addr_b. Sel 01 → addr_r if jmp_sel==10, else addr_i. Targets are used unmodified; no alignment check.
- flush = redirect_taken, combinational. When flush is 1, fetch_valid is 0.
- PC arithmetic is modulo 2^ADDR_W. pc + INSTR_BYTES at the top of the address space wraps to 0.
- Memory protocol: once imem_req rises, imem_req and imem_addr stay stable until imem_ready. A transaction is never cancelled.
- States:
  - BOOT: imem_req=0. Next cycle → FETCH. A redirect in BOOT loads pc ← target.
  - FETCH: imem_req=1, imem_addr=pc.
    - redirect_taken && imem_ready: discard imem_rdata, pc ← target, stay FETCH.
    - redirect_taken && !imem_ready: pend_pc ← target, → DRAIN.
    - imem_ready && !stall: fetch_valid=1, instr=imem_rdata, instr_pc=pc, pc ← pc+INSTR_BYTES, stay FETCH.
    - imem_ready && stall: instr_q ← imem_rdata, pc_q ← pc, pc ← pc+INSTR_BYTES, → HOLD.
    - No imem_ready: hold all state.
  - DRAIN: imem_req=1, imem_addr=old pc.
    - A new redirect_taken overwrites pend_pc (last wins) and asserts flush again.
    - On imem_ready: discard data. pc ← (redirect_taken ? new target : pend_pc), → FETCH.
  - HOLD: imem_req=0.
    - redirect_taken: drop buffer, pc ← target, → FETCH.
    - Else !stall: fetch_valid=1, instr=instr_q, instr_pc=pc_q, → FETCH.
    - Else stay HOLD.
- Priority in every state: redirect > delivery > stall.

## Timing
- Reset values, asynchronous: state BOOT, pc=RESET_PC, imem_addr=RESET_PC, imem_req=0, fetch_valid=0, flush=0, instr=0, instr_pc=0, instr_pc4=INSTR_BYTES, pend_pc=0, instr_q=0.
- First request: imem_req rises in the first cycle after rst deasserts plus one BOOT cycle.
- Zero-wait memory (imem_ready=1 always), no stall: one instruction per cycle, and fetch_valid is in the same cycle as the handshake.
- Redirect latency: with ready memory, the target address appears on imem_addr in the cycle after redirect_taken. In DRAIN, it appears in the cycle after the drained handshake.
- HOLD → FETCH: the new request issues in the cycle after the buffered delivery. There is a 1-cycle bubble.
- Reset asserted mid-transaction: outputs return to reset values immediately. The pending memory response is ignored by protocol.

## Test plan
- Reset release, RESET_PC=0x100, imem_ready=1 → BOOT for 1 cycle. Then imem_addr 0x100, 0x104, 0x108 on consecutive cycles, with fetch_valid=1 and instr_pc4 = instr_pc+4.
- Branch: redirect_valid=1, sel=11, addr_b=0x200, imem_ready=1 → flush=1 and fetch_valid=0 that cycle. Next imem_addr=0x200.
- Jump selection: sel=01, jmp_sel=10, addr_r=0x300, addr_i=0x400 → next fetch 0x300. Repeat with jmp_sel=01 → 0x400. sel=10 with redirect_valid=1 → no flush, sequential.
- Redirect during wait: imem_ready=0 for 3 cycles at 0x104, and redirect to 0x500 in cycle 1 → imem_addr stays 0x104 until ready, the data is discarded, and the next imem_addr=0x500. A second redirect to 0x600 during DRAIN → the next fetch is 0x600.
- Stall: stall=1 when 0x108 returns → HOLD, imem_req=0, fetch_valid=0. When stall drops → instr from 0x108 delivered once, then request 0x10C.
- Wrap: pc=2^ADDR_W−4, sequential fetch → next imem_addr=0.
